// File: rtl/mult_sequencer.sv
// Unsigned IN_W x IN_W shift-add multiplier with saturating OUT_W-bit result and overflow flag.
// One product per IN_W+2 cycles; start is sampled only in IDLE, so there is no queuing.
module mult_sequencer #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] result,
  output logic             ovf
);

  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

  logic [1:0]        state_q, state_d;
  logic [IN_W-1:0]   a_q, a_d;
  logic [IN_W-1:0]   b_q, b_d;
  logic [2*IN_W-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;

  logic [2*IN_W-1:0] sum;
  logic              sat;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    // Accumulator after the current step; on the last step this is the full product.
    sum = acc_q + (b_q[0] ? ({{IN_W{1'b0}}, a_q} << cnt_q) : '0);
    sat = |sum[2*IN_W-1:OUT_W];

    case (state_q)
      IDLE: begin
        if (start && !clr) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (clr) begin
          state_d = IDLE;
        end else begin
          acc_d = sum;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            ovf_d    = sat;
            result_d = sat ? '1 : sum[OUT_W-1:0];
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule
